// File: rtl/spi_aes_slave.sv
// SPI front end for an AES core: receives a 128-bit message and a
// 128/192/256-bit key LSB first, hands them to the core with a req/ack
// handshake, then shifts the core's result back out on miso.
module spi_aes_slave #(
    parameter int MSG_W   = 128,
    parameter int KEY_MAX = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               mosi,
    input  logic               mode,
    input  logic [1:0]         size,
    output logic               miso,
    output logic [MSG_W-1:0]   msg_out,
    output logic [KEY_MAX-1:0] key_out,
    output logic [1:0]         key_len,
    output logic               req,
    input  logic               ack,
    input  logic [MSG_W-1:0]   res_in,
    input  logic               res_valid,
    output logic               busy,
    output logic               err
);

    localparam int MI_W  = $clog2(MSG_W);
    localparam int KI_W  = $clog2(KEY_MAX);
    localparam int CNT_W = KI_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RX_MSG,
        RX_KEY,
        REQ,
        WAIT_RES,
        TX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [MSG_W-1:0]   tx_sh;
    logic [KI_W-1:0]    key_base;
    logic [CNT_W-1:0]   key_last_v;
    logic [KI_W-1:0]    key_idx;
    logic               msg_last;
    logic               key_last;
    logic               tx_last;

    // Key placement: keys are left-aligned, so shorter keys start higher up.
    always_comb begin
        key_base   = '0;
        key_last_v = CNT_W'(KEY_MAX - 1);
        case (key_len)
            2'b00: begin
                key_base   = KI_W'(KEY_MAX - 128);
                key_last_v = CNT_W'(127);
            end
            2'b01: begin
                key_base   = KI_W'(KEY_MAX - 192);
                key_last_v = CNT_W'(191);
            end
            default: begin
                key_base   = '0;
                key_last_v = CNT_W'(KEY_MAX - 1);
            end
        endcase
    end

    assign key_idx  = key_base + cnt[KI_W-1:0];
    assign msg_last = (cnt == CNT_W'(MSG_W - 1));
    assign key_last = (cnt == key_last_v);
    assign tx_last  = (cnt == CNT_W'(MSG_W - 1));

    assign busy = (state != IDLE);
    assign req  = (state == REQ);
    assign miso = (state == TX) & tx_sh[0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; cs only aborts while bits are actually moving.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!cs) state_nxt = (size == 2'b11) ? DONE : RX_MSG;
            end
            RX_MSG: begin
                if (cs)            state_nxt = IDLE;
                else if (mode)     state_nxt = DONE;
                else if (msg_last) state_nxt = RX_KEY;
            end
            RX_KEY: begin
                if (cs)            state_nxt = IDLE;
                else if (mode)     state_nxt = DONE;
                else if (key_last) state_nxt = REQ;
            end
            REQ: begin
                if (ack) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid) state_nxt = TX;
            end
            TX: begin
                if (cs)                   state_nxt = IDLE;
                else if (mode && tx_last) state_nxt = DONE;
            end
            DONE: begin
                if (cs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bit counter, message/key capture, result shifter, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            msg_out <= '0;
            key_out <= '0;
            key_len <= 2'b00;
            tx_sh   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        key_len <= size;
                        err     <= (size == 2'b11);
                        cnt     <= '0;
                        key_out <= '0;
                    end
                end
                RX_MSG: begin
                    if (cs || mode) begin
                        err <= 1'b1;
                    end else begin
                        msg_out[cnt[MI_W-1:0]] <= mosi;
                        cnt <= msg_last ? '0 : cnt + 1'b1;
                    end
                end
                RX_KEY: begin
                    if (cs || mode) begin
                        err <= 1'b1;
                    end else begin
                        key_out[key_idx] <= mosi;
                        cnt <= key_last ? '0 : cnt + 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        tx_sh <= res_in;
                        cnt   <= '0;
                    end
                end
                TX: begin
                    if (cs) begin
                        err <= 1'b1;
                    end else if (mode) begin
                        tx_sh <= tx_sh >> 1;
                        cnt   <= tx_last ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_slave.sv
// Bench for spi_aes_slave: frames of each key size, handshake, readback,
// aborts, reserved size and reset during readback.
module tb_spi_aes_slave;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         mosi;
    logic         mode;
    logic [1:0]   size;
    logic         miso;
    logic [127:0] msg_out;
    logic [255:0] key_out;
    logic [1:0]   key_len;
    logic         req;
    logic         ack;
    logic [127:0] res_in;
    logic         res_valid;
    logic         busy;
    logic         err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [127:0] msg_q[$];
    logic [255:0] key_q[$];
    logic [127:0] res_q[$];

    spi_aes_slave #(.MSG_W(128), .KEY_MAX(256)) dut (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .mode(mode),
        .size(size), .miso(miso), .msg_out(msg_out), .key_out(key_out),
        .key_len(key_len), .req(req), .ack(ack), .res_in(res_in),
        .res_valid(res_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] sz);
        cs = 1'b0; size = sz; mode = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [255:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = v[i];
            tick();
        end
        mosi = 1'b0;
    endtask

    // Reads the result from TX; a stall with mode=0 is inserted at stall_at.
    task automatic read_result(input int stall_at, output logic [127:0] got);
        got = '0;
        mode = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i == stall_at) begin
                mode = 1'b0;
                tick(); tick(); tick();
                mode = 1'b1;
            end
            got[i] = miso;
            tick();
        end
        mode = 1'b0;
    endtask

    task automatic finish_frame(input logic [127:0] r, output logic [127:0] got);
        ack = 1'b1; tick(); ack = 1'b0;
        res_in = r; res_valid = 1'b1; tick(); res_valid = 1'b0; res_in = '0;
        cs = 1'b0;
        read_result(-1, got);
        cs = 1'b1; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; mosi = 1'b0; mode = 1'b0; size = 2'b00;
        ack = 1'b0; res_in = '0; res_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_cnt++;
        if ({busy, req, err, miso, key_len} !== 6'b0) $display("FAIL reset_ctrl got %b want 000000", {busy, req, err, miso, key_len});
        else pass_cnt++;
        check_cnt++;
        if (msg_out !== '0 || key_out !== '0) $display("FAIL reset_data msg %h key %h want 0", msg_out, key_out);
        else pass_cnt++;
    endtask

    task automatic test_aes128();
        logic [127:0] msg = 128'h3243f6a8885a308d313198a2e0370734;
        logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] em;
        logic [255:0] ek;
        msg_q.push_back(msg);
        key_q.push_back({key, 128'h0});
        start_frame(2'b00);
        check_cnt++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL start128 busy %b err %b want 1 0", busy, err);
        else pass_cnt++;
        send_bits({128'h0, msg}, 128);
        send_bits({128'h0, key}, 127);
        check_cnt++;
        if (req !== 1'b0) $display("FAIL req_early128 got %b want 0", req);
        else pass_cnt++;
        mosi = key[127]; tick(); mosi = 1'b0;
        check_cnt++;
        if (req !== 1'b1) $display("FAIL req_cycle257 got %b want 1", req);
        else pass_cnt++;
        if (req === 1'b1) begin
            em = msg_q.pop_front();
            ek = key_q.pop_front();
            check_cnt++;
            if (msg_out !== em) $display("FAIL msg128 got %h want %h", msg_out, em);
            else pass_cnt++;
            check_cnt++;
            if (key_out !== ek || key_len !== 2'b00) $display("FAIL key128 got %h/%b want %h/00", key_out, key_len, ek);
            else pass_cnt++;
        end
    endtask

    task automatic test_handshake();
        logic [127:0] res = 128'h3925841d02dc09fbdc118597196a0b32;
        logic [127:0] got;
        logic [127:0] er;
        int drops = 0;
        ack = 1'b0; res_valid = 1'b1; res_in = 128'hdeadbeef;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req !== 1'b1) drops++;
        end
        res_valid = 1'b0; res_in = '0;
        check_cnt++;
        if (drops != 0) $display("FAIL req_hold drops %0d want 0", drops);
        else pass_cnt++;
        ack = 1'b1; tick(); ack = 1'b0;
        check_cnt++;
        if (req !== 1'b0 || busy !== 1'b1) $display("FAIL ack_accept req %b busy %b want 0 1", req, busy);
        else pass_cnt++;
        tick(); tick();
        check_cnt++;
        if (miso !== 1'b0 || busy !== 1'b1) $display("FAIL wait_res miso %b busy %b want 0 1", miso, busy);
        else pass_cnt++;
        res_q.push_back(res);
        res_in = res; res_valid = 1'b1; tick(); res_valid = 1'b0; res_in = '0;
        read_result(50, got);
        er = res_q.pop_front();
        check_cnt++;
        if (got !== er) $display("FAIL miso_stream got %h want %h", got, er);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b1 || miso !== 1'b0 || msg_out !== 128'h3243f6a8885a308d313198a2e0370734)
            $display("FAIL done_state busy %b miso %b msg %h want 1 0 stable", busy, miso, msg_out);
        else pass_cnt++;
        tick();
        cs = 1'b1; tick();
        check_cnt++;
        if (busy !== 1'b0 || err !== 1'b0) $display("FAIL done_idle busy %b err %b want 0 0", busy, err);
        else pass_cnt++;
    endtask

    task automatic test_aes192();
        logic [127:0] msg = 128'h00112233445566778899aabbccddeeff;
        logic [191:0] key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        logic [127:0] res = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        logic [127:0] got;
        logic [255:0] ek;
        key_q.push_back({key, 64'h0});
        start_frame(2'b01);
        send_bits({128'h0, msg}, 128);
        send_bits({64'h0, key}, 191);
        check_cnt++;
        if (req !== 1'b0) $display("FAIL req_early192 got %b want 0", req);
        else pass_cnt++;
        mosi = key[191]; tick(); mosi = 1'b0;
        check_cnt++;
        if (req !== 1'b1) $display("FAIL req_cycle321 got %b want 1", req);
        else pass_cnt++;
        ek = key_q.pop_front();
        check_cnt++;
        if (key_out !== ek || key_len !== 2'b01) $display("FAIL key192 got %h/%b want %h/01", key_out, key_len, ek);
        else pass_cnt++;
        cs = 1'b1; tick(); tick();
        check_cnt++;
        if (req !== 1'b1 || err !== 1'b0) $display("FAIL cs_in_req req %b err %b want 1 0", req, err);
        else pass_cnt++;
        ack = 1'b1; tick(); ack = 1'b0;
        res_q.push_back(res);
        res_in = res; res_valid = 1'b1; tick(); res_valid = 1'b0; res_in = '0;
        cs = 1'b0;
        read_result(-1, got);
        check_cnt++;
        if (got !== res_q.pop_front() || err !== 1'b0) $display("FAIL result192 got %h err %b want %h 0", got, err, res);
        else pass_cnt++;
        cs = 1'b1; tick();
    endtask

    task automatic test_abort();
        logic [255:0] key = {128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4};
        logic [127:0] msg = 128'h6bc1bee22e409f96e93d7e117393172a;
        logic [127:0] res = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
        logic [127:0] got;
        start_frame(2'b00);
        send_bits({128'h0, msg}, 60);
        cs = 1'b1; tick();
        check_cnt++;
        if (err !== 1'b1 || busy !== 1'b0 || req !== 1'b0) $display("FAIL abort_msg err %b busy %b req %b want 1 0 0", err, busy, req);
        else pass_cnt++;
        res_q.push_back(res);
        start_frame(2'b10);
        check_cnt++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL err_clear err %b busy %b want 0 1", err, busy);
        else pass_cnt++;
        send_bits({128'h0, msg}, 128);
        send_bits(key, 256);
        check_cnt++;
        if (req !== 1'b1 || key_out !== key || key_len !== 2'b10 || msg_out !== msg)
            $display("FAIL frame256 req %b key %h len %b want 1 %h 10", req, key_out, key_len, key);
        else pass_cnt++;
        finish_frame(res, got);
        check_cnt++;
        if (got !== res_q.pop_front() || err !== 1'b0 || busy !== 1'b0) $display("FAIL result256 got %h err %b busy %b want %h 0 0", got, err, busy, res);
        else pass_cnt++;
        start_frame(2'b00);
        send_bits({128'h0, msg}, 128);
        send_bits({128'h0, key[127:0]}, 10);
        mode = 1'b1; tick(); mode = 1'b0;
        check_cnt++;
        if (err !== 1'b1 || busy !== 1'b1 || req !== 1'b0) $display("FAIL mode_in_rx err %b busy %b req %b want 1 1 0", err, busy, req);
        else pass_cnt++;
        cs = 1'b1; tick();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL mode_rx_idle busy %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reserved();
        int req_seen = 0;
        start_frame(2'b11);
        check_cnt++;
        if (err !== 1'b1 || busy !== 1'b1 || key_len !== 2'b11) $display("FAIL reserved_size err %b busy %b len %b want 1 1 11", err, busy, key_len);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            mosi = i[0];
            tick();
            if (req !== 1'b0) req_seen++;
        end
        mosi = 1'b0;
        check_cnt++;
        if (req_seen != 0 || busy !== 1'b1) $display("FAIL reserved_noreq req_cycles %0d busy %b want 0 1", req_seen, busy);
        else pass_cnt++;
        cs = 1'b1; tick();
        check_cnt++;
        if (busy !== 1'b0 || err !== 1'b1) $display("FAIL reserved_idle busy %b err %b want 0 1", busy, err);
        else pass_cnt++;
    endtask

    task automatic test_reset_tx();
        logic [127:0] msg = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start_frame(2'b00);
        send_bits({128'h0, msg}, 128);
        send_bits({128'h0, key}, 128);
        ack = 1'b1; tick(); ack = 1'b0;
        res_in = '1; res_valid = 1'b1; tick(); res_valid = 1'b0; res_in = '0;
        mode = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_cnt++;
        if (busy !== 1'b1 || miso !== 1'b1) $display("FAIL tx_before_reset busy %b miso %b want 1 1", busy, miso);
        else pass_cnt++;
        reset = 1'b1; tick(); reset = 1'b0;
        check_cnt++;
        if ({miso, busy, req, err, key_len} !== 6'b0) $display("FAIL reset_tx_ctrl got %b want 000000", {miso, busy, req, err, key_len});
        else pass_cnt++;
        check_cnt++;
        if (msg_out !== '0 || key_out !== '0) $display("FAIL reset_tx_data msg %h key %h want 0", msg_out, key_out);
        else pass_cnt++;
        mode = 1'b0; cs = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_handshake();
        test_aes192();
        test_abort();
        test_reserved();
        test_reset_tx();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
